// File: rtl/neuron_mac_if.sv
// neuron_mac handshake/memory bundle.
// master drives the engine, slave is the engine.
interface neuron_mac_if;
  logic        start;
  logic [31:0] bias;
  logic        busy;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] x_addr;
  logic [31:0] x_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output start, bias, w_data, x_data, out_ready,
    input  busy, w_addr, x_addr, out_valid, out_data
  );

  modport slave (
    input  start, bias, w_data, x_data, out_ready,
    output busy, w_addr, x_addr, out_valid, out_data
  );
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron signed fixed-point MAC.
// Sweeps weight/input memories, saturates, optional ReLU.
module neuron_mac #(
  parameter int NUM_INPUTS = 784,
  parameter int FRAC_BITS  = 16,
  parameter int RELU       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  neuron_mac_if.slave  io
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int ACC_W = 64 + $clog2(NUM_INPUTS) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN,
    S_OUT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    r_out_valid;
  logic                    w_valid_nxt;
  logic [31:0]             r_out_data;
  logic [31:0]             w_data_nxt;

  logic [63:0]             w_w64;
  logic [63:0]             w_x64;
  logic signed [63:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_shift;
  logic                    w_ovf;
  logic [31:0]             w_sat;
  logic [31:0]             w_result;

  // Product fits 64 bits, so a 64x64 low-half multiply is exact.
  assign w_w64  = {{32{io.w_data[31]}}, io.w_data};
  assign w_x64  = {{32{io.x_data[31]}}, io.x_data};
  assign w_prod = $signed(w_w64) * $signed(w_x64);

  assign w_prod_ext = {{(ACC_W-64){w_prod[63]}}, w_prod};
  assign w_bias_ext = $signed({{(ACC_W-32){io.bias[31]}}, io.bias})
                      <<< FRAC_BITS;

  // Overflow when bits above 31 are not a pure sign extension.
  assign w_shift = r_acc >>> FRAC_BITS;
  assign w_ovf   = w_shift[ACC_W-1:31] != {(ACC_W-31){w_shift[31]}};
  assign w_sat   = !w_ovf ? w_shift[31:0] :
                   w_shift[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  assign w_result = (RELU != 0 && w_sat[31]) ? 32'h0 : w_sat;

  assign io.busy      = r_state != S_IDLE;
  assign io.w_addr    = (r_state == S_RUN) ? 32'(r_idx) : 32'h0;
  assign io.x_addr    = (r_state == S_RUN) ? 32'(r_idx) : 32'h0;
  assign io.out_valid = r_out_valid;
  assign io.out_data  = r_out_data;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_data_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_valid_nxt = r_out_valid;
    w_data_nxt  = r_out_data;
    unique case (r_state)
      S_IDLE: begin
        if (io.start) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
          w_acc_nxt   = w_bias_ext;
        end
      end
      S_RUN: begin
        w_acc_nxt = r_acc + w_prod_ext;
        if (r_idx == LAST) begin
          w_state_nxt = S_FIN;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_FIN: begin
        w_data_nxt  = w_result;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (r_out_valid && io.out_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: scoreboard bench for neuron_mac.
// Three instances: N=4 ReLU, N=4 signed, default.
module tb_neuron_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  neuron_mac_if a_if ();
  neuron_mac_if b_if ();
  neuron_mac_if c_if ();

  neuron_mac #(.NUM_INPUTS(4), .FRAC_BITS(16), .RELU(1)) u_a (
    .clk(clk), .rst_n(rst_n), .io(a_if.slave)
  );
  neuron_mac #(.NUM_INPUTS(4), .FRAC_BITS(16), .RELU(0)) u_b (
    .clk(clk), .rst_n(rst_n), .io(b_if.slave)
  );
  neuron_mac u_c (
    .clk(clk), .rst_n(rst_n), .io(c_if.slave)
  );

  logic [31:0] wm [4];
  logic [31:0] xm [4];

  assign a_if.w_data = wm[a_if.w_addr[1:0]];
  assign a_if.x_data = xm[a_if.x_addr[1:0]];
  assign b_if.w_data = wm[b_if.w_addr[1:0]];
  assign b_if.x_data = xm[b_if.x_addr[1:0]];
  assign c_if.w_data = 32'h0000_0100;
  assign c_if.x_data = 32'h0000_0100;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  function automatic logic vld(input int s);
    case (s)
      0: return a_if.out_valid;
      1: return b_if.out_valid;
      default: return c_if.out_valid;
    endcase
  endfunction

  function automatic logic bsy(input int s);
    case (s)
      0: return a_if.busy;
      1: return b_if.busy;
      default: return c_if.busy;
    endcase
  endfunction

  function automatic logic [31:0] dat(input int s);
    case (s)
      0: return a_if.out_data;
      1: return b_if.out_data;
      default: return c_if.out_data;
    endcase
  endfunction

  function automatic logic [31:0] wad(input int s);
    case (s)
      0: return a_if.w_addr;
      1: return b_if.w_addr;
      default: return c_if.w_addr;
    endcase
  endfunction

  function automatic logic [31:0] xad(input int s);
    case (s)
      0: return a_if.x_addr;
      1: return b_if.x_addr;
      default: return c_if.x_addr;
    endcase
  endfunction

  task automatic set_start(input int s, input logic st,
                           input logic [31:0] b);
    case (s)
      0: begin a_if.start = st; a_if.bias = b; end
      1: begin b_if.start = st; b_if.bias = b; end
      default: begin c_if.start = st; c_if.bias = b; end
    endcase
  endtask

  task automatic set_ready(input int s, input logic r);
    case (s)
      0: a_if.out_ready = r;
      1: b_if.out_ready = r;
      default: c_if.out_ready = r;
    endcase
  endtask

  task automatic set_mem(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [31:0] x3);
    wm[0] = w0; wm[1] = w1; wm[2] = w2; wm[3] = w3;
    xm[0] = x0; xm[1] = x1; xm[2] = x2; xm[3] = x3;
  endtask

  // Start, scramble bias after the start edge, wait for out_valid.
  // lat counts edges from the start edge to the valid edge inclusive.
  task automatic go(input int s, input logic [31:0] b,
                    output int lat, output int unsigned e0);
    set_start(s, 1'b1, b);
    @(posedge clk);
    #1;
    e0  = edges;
    lat = 1;
    set_start(s, 1'b0, $urandom);
    while (!vld(s) && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept(input int s);
    set_ready(s, 1'b1);
    @(posedge clk);
    #1;
    set_ready(s, 1'b0);
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      set_start(s, 1'b0, 32'h0);
      set_ready(s, 1'b0);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (bsy(s) !== 1'b0 || vld(s) !== 1'b0 || dat(s) !== 32'h0 ||
          wad(s) !== 32'h0 || xad(s) !== 32'h0) begin
        errors++;
        $display("FAIL reset[%0d] busy=%b valid=%b data=%h wa=%h xa=%h exp all 0",
                 s, bsy(s), vld(s), dat(s), wad(s), xad(s));
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int lat;
    int unsigned e0;
    logic [31:0] exp;
    set_mem(32'h10000, 32'h10000, 32'h10000, 32'h10000,
            32'h10000, 32'h20000, 32'h30000, 32'h40000);
    exp_q.push_back(32'h000A_8000);
    go(0, 32'h0000_8000, lat, e0);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 6", lat);
    end
    checks++;
    if (dat(0) !== exp) begin
      errors++;
      $display("FAIL basic_data got %h exp %h", dat(0), exp);
    end
    accept(0);
    checks++;
    if (vld(0) !== 1'b0 || bsy(0) !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept valid=%b busy=%b exp 0 0", vld(0), bsy(0));
    end
  endtask

  task automatic test_signed;
    int lat;
    int unsigned e0;
    logic [31:0] exp;
    set_mem(32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000,
            32'h20000, 32'h20000, 32'h20000, 32'h20000);
    for (int s = 0; s < 2; s++) begin
      exp_q.push_back(s == 0 ? 32'h0 : 32'hFFF8_0000);
      go(s, 32'h0, lat, e0);
      exp = exp_q.pop_front();
      checks++;
      if (!vld(s) || dat(s) !== exp) begin
        errors++;
        $display("FAIL signed[%0d] valid=%b got %h exp %h",
                 s, vld(s), dat(s), exp);
      end
      accept(s);
    end
  endtask

  task automatic test_saturation;
    int lat;
    int unsigned e0;
    logic [31:0] exp;
    set_mem(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
            32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    exp_q.push_back(32'h7FFF_FFFF);
    go(0, 32'h7FFF_FFFF, lat, e0);
    exp = exp_q.pop_front();
    checks++;
    if (!vld(0) || dat(0) !== exp) begin
      errors++;
      $display("FAIL sat_pos valid=%b got %h exp %h", vld(0), dat(0), exp);
    end
    accept(0);
    for (int i = 0; i < 4; i++) wm[i] = 32'h8000_0001;
    exp_q.push_back(32'h8000_0000);
    go(1, 32'h7FFF_FFFF, lat, e0);
    exp = exp_q.pop_front();
    checks++;
    if (!vld(1) || dat(1) !== exp) begin
      errors++;
      $display("FAIL sat_neg valid=%b got %h exp %h", vld(1), dat(1), exp);
    end
    accept(1);
  endtask

  task automatic test_backpressure;
    int lat;
    int unsigned e0;
    logic [31:0] exp;
    set_mem(32'h10000, 32'h10000, 32'h10000, 32'h10000,
            32'h10000, 32'h20000, 32'h30000, 32'h40000);
    exp_q.push_back(32'h000A_8000);
    go(0, 32'h0000_8000, lat, e0);
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      set_start(0, 1'b1, 32'h0);
      @(posedge clk);
      #1;
      checks++;
      if (vld(0) !== 1'b1 || bsy(0) !== 1'b1 || dat(0) !== exp) begin
        errors++;
        $display("FAIL hold[%0d] valid=%b busy=%b got %h exp 1 1 %h",
                 i, vld(0), bsy(0), dat(0), exp);
      end
    end
    set_ready(0, 1'b1);
    @(posedge clk);
    #1;
    set_ready(0, 1'b0);
    checks++;
    if (vld(0) !== 1'b0 || bsy(0) !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept valid=%b busy=%b exp 0 0", vld(0), bsy(0));
    end
    set_start(0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    checks++;
    if (bsy(0) !== 1'b0) begin
      errors++;
      $display("FAIL start_in_accept busy=%b exp 0", bsy(0));
    end
    exp_q.push_back(32'h000A_8000);
    go(0, 32'h0000_8000, lat, e0);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 6 || dat(0) !== exp) begin
      errors++;
      $display("FAIL bp_restart lat=%0d got %h exp 6 %h", lat, dat(0), exp);
    end
    accept(0);
  endtask

  task automatic test_sweep;
    logic [31:0] exp;
    int n;
    exp_q.push_back(32'h000A_8000);
    set_start(0, 1'b1, 32'h0000_8000);
    #1;
    checks++;
    if (wad(0) !== 32'h0 || xad(0) !== 32'h0) begin
      errors++;
      $display("FAIL addr_idle wa=%h xa=%h exp 0", wad(0), xad(0));
    end
    @(posedge clk);
    #1;
    set_start(0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wad(0) !== 32'(k) || xad(0) !== 32'(k)) begin
        errors++;
        $display("FAIL addr[%0d] wa=%h xa=%h exp %h", k, wad(0), xad(0), k);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (wad(0) !== 32'h0 || xad(0) !== 32'h0 || bsy(0) !== 1'b1) begin
      errors++;
      $display("FAIL addr_fin wa=%h xa=%h busy=%b exp 0 0 1",
               wad(0), xad(0), bsy(0));
    end
    n = 0;
    while (!vld(0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (!vld(0) || dat(0) !== exp || wad(0) !== 32'h0) begin
      errors++;
      $display("FAIL sweep_out valid=%b got %h wa=%h exp %h",
               vld(0), dat(0), wad(0), exp);
    end
    accept(0);
  endtask

  task automatic test_reset_midrun;
    int lat;
    int unsigned e0;
    int seen;
    logic [31:0] exp;
    set_start(0, 1'b1, 32'h0000_8000);
    @(posedge clk);
    #1;
    set_start(0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (wad(0) !== 32'h2) begin
      errors++;
      $display("FAIL midrun_idx wa=%h exp 2", wad(0));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bsy(0) !== 1'b0 || vld(0) !== 1'b0 || dat(0) !== 32'h0 ||
        wad(0) !== 32'h0 || xad(0) !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset busy=%b valid=%b data=%h wa=%h exp 0",
               bsy(0), vld(0), dat(0), wad(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (vld(0)) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_valid got %0d valid cycles exp 0", seen);
    end
    exp_q.push_back(32'h000A_8000);
    go(0, 32'h0000_8000, lat, e0);
    exp = exp_q.pop_front();
    checks++;
    if (!vld(0) || dat(0) !== exp) begin
      errors++;
      $display("FAIL midrun_fresh valid=%b got %h exp %h", vld(0), dat(0), exp);
    end
    accept(0);
  endtask

  task automatic test_back_to_back;
    int lat;
    int unsigned e0;
    int unsigned e1;
    logic [31:0] exp;
    set_ready(0, 1'b1);
    exp_q.push_back(32'h000A_8000);
    exp_q.push_back(32'h000A_0000);
    go(0, 32'h0000_8000, lat, e0);
    exp = exp_q.pop_front();
    checks++;
    if (!vld(0) || dat(0) !== exp) begin
      errors++;
      $display("FAIL b2b_first valid=%b got %h exp %h", vld(0), dat(0), exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (vld(0) !== 1'b0 || bsy(0) !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept valid=%b busy=%b exp 0 0", vld(0), bsy(0));
    end
    go(0, 32'h0, lat, e1);
    exp = exp_q.pop_front();
    checks++;
    if (e1 - e0 !== 7) begin
      errors++;
      $display("FAIL b2b_period got %0d exp 7", e1 - e0);
    end
    checks++;
    if (!vld(0) || lat !== 6 || dat(0) !== exp) begin
      errors++;
      $display("FAIL b2b_second valid=%b lat=%0d got %h exp %h",
               vld(0), lat, dat(0), exp);
    end
    @(posedge clk);
    #1;
    set_ready(0, 1'b0);
    checks++;
    if (vld(0) !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop valid=%b exp 0", vld(0));
    end
  endtask

  task automatic test_default;
    int lat;
    int unsigned e0;
    logic [31:0] exp;
    exp_q.push_back(32'h0000_0310);
    go(2, 32'h0, lat, e0);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 786) begin
      errors++;
      $display("FAIL default_latency got %0d exp 786", lat);
    end
    checks++;
    if (!vld(2) || dat(2) !== exp) begin
      errors++;
      $display("FAIL default_data valid=%b got %h exp %h", vld(2), dat(2), exp);
    end
    accept(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_saturation();
    test_backpressure();
    test_sweep();
    test_reset_midrun();
    test_back_to_back();
    test_default();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
